// File: rtl/ws2812_serializer_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_serializer_pkg
// Shared definitions for the WS2812 serializer:
//   - SEGMENTS_PER_BIT : bit_segment_clock periods that make up one data bit
//   - state_t          : serializer FSM states
//   - default BITS_PER_LED and LATCH_BITS values for the top module
// No ports (package).
// -----------------------------------------------------------------------------
package ws2812_serializer_pkg;

  localparam int SEGMENTS_PER_BIT     = 3;
  localparam int DEFAULT_BITS_PER_LED = 24;
  localparam int DEFAULT_LATCH_BITS   = 64;

  // Index of the final segment of a bit (the always-low one)
  localparam logic [1:0] SEG_LAST = 2'(SEGMENTS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    ALIGN    = 3'd2,
    SHIFT    = 3'd3,
    LATCH    = 3'd4
  } state_t;

endpackage

// File: rtl/ws2812_serializer_edge_strobe.sv
// -----------------------------------------------------------------------------
// ws2812_serializer_edge_strobe
// Two-flop synchroniser followed by a rising-edge detector. Produces a
// registered one-cycle strobe three clocks after the input's rising edge.
// Ports:
//   clock_12mhz  in   system clock
//   reset        in   synchronous, active-high
//   level        in   asynchronous level to watch
//   strobe       out  one-cycle pulse per rising edge of level
// -----------------------------------------------------------------------------
module ws2812_serializer_edge_strobe (
  input  logic clock_12mhz,
  input  logic reset,
  input  logic level,
  output logic strobe
);

  // sync_q[1:0] is the synchroniser pair; sync_q[2] remembers the previous
  // synchronised level so a rising edge is seen exactly once.
  logic [2:0] sync_q;

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      sync_q <= 3'b000;
      strobe <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], level};
      strobe <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/ws2812_serializer.sv
// -----------------------------------------------------------------------------
// ws2812_serializer
// Serialises one frame of pixel words onto the single-wire WS2812 line.
// Each bit is three bit_segment_clock periods: high, data, low. A frame starts
// on a framerate rising edge, pixels are fetched one ahead through a
// req/valid handshake, and the frame ends with LATCH_BITS bit periods low.
//
// Optional feature: define WS2812_SERIALIZER_GRB_ORDER_EN to treat pixel_data
// as {R,G,B} and send it as {G,R,B} (BITS_PER_LED must be 24).
//
// Ports:
//   clock_12mhz        in   system clock
//   reset              in   synchronous, active-high
//   bit_segment_clock  in   segment timing, three periods per bit
//   bit_clock          in   bit boundary reference
//   framerate          in   rising edge requests a frame
//   pixel_req          out  a pixel word is requested
//   pixel_addr         out  LED index requested
//   pixel_data         in   pixel word, valid with pixel_valid
//   pixel_valid        in   one-cycle acknowledge of pixel_req
//   led_data           out  WS2812 data line
//   frame_busy         out  high from frame start to latch end
//   underrun           out  sticky late-pixel flag, cleared at frame start
// -----------------------------------------------------------------------------
module ws2812_serializer
  import ws2812_serializer_pkg::*;
#(
  parameter int LED_COUNT    = 60,
  parameter int BITS_PER_LED = DEFAULT_BITS_PER_LED,
  parameter int LATCH_BITS   = DEFAULT_LATCH_BITS,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock_12mhz,
  input  logic                    reset,
  input  logic                    bit_segment_clock,
  input  logic                    bit_clock,
  input  logic                    framerate,
  output logic                    pixel_req,
  output logic [ADDR_WIDTH-1:0]   pixel_addr,
  input  logic [BITS_PER_LED-1:0] pixel_data,
  input  logic                    pixel_valid,
  output logic                    led_data,
  output logic                    frame_busy,
  output logic                    underrun
);

  localparam int BIT_W   = $clog2(BITS_PER_LED + 1);
  localparam int LATCH_W = $clog2(LATCH_BITS + 1);
  localparam logic [BIT_W-1:0]      BIT_LAST   = BIT_W'(BITS_PER_LED - 1);
  localparam logic [LATCH_W-1:0]    LATCH_LAST = LATCH_W'(LATCH_BITS - 1);
  localparam logic [ADDR_WIDTH:0]   LED_TOTAL  = (ADDR_WIDTH + 1)'(LED_COUNT);
  localparam logic [ADDR_WIDTH:0]   ONE_EXT    = (ADDR_WIDTH + 1)'(1);

  state_t                  state, state_d;
  logic [1:0]              seg_cnt, seg_cnt_d;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]   led_cnt, led_cnt_d;
  logic [LATCH_W-1:0]      latch_cnt, latch_cnt_d;
  logic [BITS_PER_LED-1:0] shift_reg, shift_reg_d;
  logic [BITS_PER_LED-1:0] prefetch_reg, prefetch_reg_d;
  logic                    prefetch_full, prefetch_full_d;
  logic                    pixel_req_d;
  logic [ADDR_WIDTH-1:0]   pixel_addr_d;
  logic                    led_data_d, frame_busy_d, underrun_d;

  logic                    seg_stb, bit_stb, frame_stb;
  logic [BITS_PER_LED-1:0] load_word;
  logic                    accept, word_is_next, led_end;
  logic [ADDR_WIDTH:0]     next_led;

  ws2812_serializer_edge_strobe u_seg_strobe (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .level       (bit_segment_clock),
    .strobe      (seg_stb)
  );

  ws2812_serializer_edge_strobe u_bit_strobe (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .level       (bit_clock),
    .strobe      (bit_stb)
  );

  ws2812_serializer_edge_strobe u_frame_strobe (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .level       (framerate),
    .strobe      (frame_stb)
  );

`ifdef WS2812_SERIALIZER_GRB_ORDER_EN
  assign load_word = {pixel_data[15:8], pixel_data[23:16], pixel_data[7:0]};
`else
  assign load_word = pixel_data;
`endif

  assign accept       = pixel_req & pixel_valid;
  assign next_led     = {1'b0, led_cnt} + ONE_EXT;
  // An arriving word belongs in the prefetch slot only if it is for the LED
  // after the one on the wire; anything older arrived too late.
  assign word_is_next = ({1'b0, pixel_addr} == next_led);
  assign led_end      = (state == SHIFT) && seg_stb && (seg_cnt == SEG_LAST) &&
                        (bit_cnt == BIT_LAST);

  // Next-state and datapath decode. Requests are re-issued for led_cnt+1
  // whenever the slot is empty and nothing is outstanding, which also covers
  // the cycle after a late word has been discarded.
  always_comb begin
    state_d         = state;
    seg_cnt_d       = seg_cnt;
    bit_cnt_d       = bit_cnt;
    led_cnt_d       = led_cnt;
    latch_cnt_d     = latch_cnt;
    shift_reg_d     = shift_reg;
    prefetch_reg_d  = prefetch_reg;
    prefetch_full_d = prefetch_full;
    pixel_req_d     = pixel_req;
    pixel_addr_d    = pixel_addr;
    led_data_d      = led_data;
    frame_busy_d    = frame_busy;
    underrun_d      = underrun;

    case (state)
      IDLE: begin
        led_data_d = 1'b0;
        if (frame_stb) begin
          frame_busy_d    = 1'b1;
          underrun_d      = 1'b0;
          pixel_addr_d    = '0;
          pixel_req_d     = 1'b1;
          led_cnt_d       = '0;
          prefetch_full_d = 1'b0;
          state_d         = PREFETCH;
        end
      end

      PREFETCH: begin
        if (accept) begin
          shift_reg_d = load_word;
          state_d     = ALIGN;
          if (LED_TOTAL > ONE_EXT) begin
            pixel_addr_d = ADDR_WIDTH'(1);
            pixel_req_d  = 1'b1;
          end else begin
            pixel_req_d = 1'b0;
          end
        end
      end

      ALIGN, SHIFT: begin
        if (accept) begin
          pixel_req_d = 1'b0;
          if (word_is_next && !led_end) begin
            prefetch_reg_d  = load_word;
            prefetch_full_d = 1'b1;
          end
        end else if (!pixel_req && !prefetch_full &&
                     ({1'b0, pixel_addr} < next_led) && (next_led < LED_TOTAL)) begin
          pixel_req_d  = 1'b1;
          pixel_addr_d = next_led[ADDR_WIDTH-1:0];
        end

        if (state == ALIGN) begin
          if (bit_stb) begin
            state_d    = SHIFT;
            seg_cnt_d  = 2'd0;
            bit_cnt_d  = '0;
            led_data_d = 1'b1;
          end
        end else if (seg_stb) begin
          case (seg_cnt)
            2'd0: begin
              seg_cnt_d  = 2'd1;
              led_data_d = shift_reg[BITS_PER_LED-1];
            end
            2'd1: begin
              seg_cnt_d  = 2'd2;
              led_data_d = 1'b0;
            end
            default: begin
              seg_cnt_d   = 2'd0;
              shift_reg_d = shift_reg << 1;
              if (bit_cnt != BIT_LAST) begin
                bit_cnt_d  = bit_cnt + BIT_W'(1);
                led_data_d = 1'b1;
              end else if (next_led == LED_TOTAL) begin
                // Last LED done: any still-outstanding request is abandoned
                state_d         = LATCH;
                led_data_d      = 1'b0;
                latch_cnt_d     = '0;
                pixel_req_d     = 1'b0;
                prefetch_full_d = 1'b0;
              end else begin
                bit_cnt_d  = '0;
                led_cnt_d  = next_led[ADDR_WIDTH-1:0];
                led_data_d = 1'b1;
                // A word arriving on this very cycle is still on time
                if (prefetch_full) begin
                  shift_reg_d     = prefetch_reg;
                  prefetch_full_d = 1'b0;
                end else if (accept && word_is_next) begin
                  shift_reg_d = load_word;
                end else begin
                  shift_reg_d = '0;
                  underrun_d  = 1'b1;
                end
              end
            end
          endcase
        end
      end

      LATCH: begin
        led_data_d = 1'b0;
        if (bit_stb) begin
          if (latch_cnt == LATCH_LAST) begin
            frame_busy_d = 1'b0;
            latch_cnt_d  = '0;
            state_d      = IDLE;
          end else begin
            latch_cnt_d = latch_cnt + LATCH_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state         <= IDLE;
      seg_cnt       <= 2'd0;
      bit_cnt       <= '0;
      led_cnt       <= '0;
      latch_cnt     <= '0;
      shift_reg     <= '0;
      prefetch_reg  <= '0;
      prefetch_full <= 1'b0;
      pixel_req     <= 1'b0;
      pixel_addr    <= '0;
      led_data      <= 1'b0;
      frame_busy    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state         <= state_d;
      seg_cnt       <= seg_cnt_d;
      bit_cnt       <= bit_cnt_d;
      led_cnt       <= led_cnt_d;
      latch_cnt     <= latch_cnt_d;
      shift_reg     <= shift_reg_d;
      prefetch_reg  <= prefetch_reg_d;
      prefetch_full <= prefetch_full_d;
      pixel_req     <= pixel_req_d;
      pixel_addr    <= pixel_addr_d;
      led_data      <= led_data_d;
      frame_busy    <= frame_busy_d;
      underrun      <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// -----------------------------------------------------------------------------
// tb_ws2812_serializer
// Scoreboarded bench for ws2812_serializer. A pixel responder answers
// requests with planned words and pushes the expected wire bits; a line
// monitor decodes led_data pulse widths back into bits and pops/compares.
// Honours WS2812_SERIALIZER_GRB_ORDER_EN in its expected wire order.
// -----------------------------------------------------------------------------
module tb_ws2812_serializer;

  localparam int LED_COUNT    = 3;
  localparam int BITS_PER_LED = 24;
  localparam int LATCH_BITS   = 40;
  localparam int ADDR_WIDTH   = 10;
  localparam int SEG_CLKS     = 8;
  localparam int BIT_CLKS     = 3 * SEG_CLKS;
  localparam int LATE_DELAY   = 700;

  logic                    clock_12mhz = 1'b0;
  logic                    reset = 1'b1;
  logic                    bit_segment_clock = 1'b0;
  logic                    bit_clock = 1'b0;
  logic                    framerate = 1'b0;
  logic                    pixel_req;
  logic [ADDR_WIDTH-1:0]   pixel_addr;
  logic [BITS_PER_LED-1:0] pixel_data = '0;
  logic                    pixel_valid = 1'b0;
  logic                    led_data;
  logic                    frame_busy;
  logic                    underrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  bit         exp_q[$];
  logic [23:0] plan_word[LED_COUNT];
  bit         plan_late[LED_COUNT];
  bit         exp_underrun = 1'b0;
  int         req_idx = 0;
  int         req_count = 0;

  ws2812_serializer #(
    .LED_COUNT    (LED_COUNT),
    .BITS_PER_LED (BITS_PER_LED),
    .LATCH_BITS   (LATCH_BITS),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) dut (
    .clock_12mhz       (clock_12mhz),
    .reset             (reset),
    .bit_segment_clock (bit_segment_clock),
    .bit_clock         (bit_clock),
    .framerate         (framerate),
    .pixel_req         (pixel_req),
    .pixel_addr        (pixel_addr),
    .pixel_data        (pixel_data),
    .pixel_valid       (pixel_valid),
    .led_data          (led_data),
    .frame_busy        (frame_busy),
    .underrun          (underrun)
  );

  initial forever #5 clock_12mhz = ~clock_12mhz;

  // Order in which a pixel word appears on the wire
  function automatic logic [23:0] wire_order(input logic [23:0] w);
`ifdef WS2812_SERIALIZER_GRB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout/none, want event (cycle %0d)", name, cyc);
  endtask

  // Segment and bit clocks: three segments per bit, rising edges aligned
  initial begin
    int phase = 0;
    forever begin
      @(negedge clock_12mhz);
      bit_segment_clock = (phase % SEG_CLKS) < (SEG_CLKS / 2);
      bit_clock         = phase < (BIT_CLKS / 2);
      phase             = (phase + 1) % BIT_CLKS;
    end
  end

  // Pixel responder: answers each request after a short random delay, or
  // after LATE_DELAY for a planned late LED, and records the expected bits.
  initial begin
    bit          pending = 1'b0;
    bit          late;
    int          countdown = 0;
    logic        prev_busy = 1'b0;
    logic [23:0] cur_word = '0;
    logic [23:0] w;
    forever begin
      @(negedge clock_12mhz);
      if (reset) begin
        pixel_valid = 1'b0;
        pending     = 1'b0;
        prev_busy   = 1'b0;
      end else begin
        if (frame_busy && !prev_busy) begin
          req_idx   = 0;
          req_count = 0;
        end
        prev_busy = frame_busy;
        if (pixel_valid) begin
          pixel_valid = 1'b0;
          pending     = 1'b0;
        end else if (pending && !pixel_req) begin
          pending = 1'b0;
        end else if (pending) begin
          if (countdown == 0) begin
            pixel_valid = 1'b1;
            pixel_data  = cur_word;
          end else begin
            countdown--;
          end
        end else if (pixel_req) begin
          check_output("pixel_addr", 32'(pixel_addr), 32'(req_idx));
          if (req_idx < LED_COUNT) begin
            cur_word = plan_word[req_idx];
            late     = plan_late[req_idx];
          end else begin
            cur_word = 24'($urandom);
            late     = 1'b0;
          end
          w = late ? 24'h0 : wire_order(cur_word);
          for (int b = 23; b >= 0; b--) exp_q.push_back(w[b]);
          countdown = late ? LATE_DELAY : int'($urandom_range(0, 4));
          pending   = 1'b1;
          req_idx++;
          req_count++;
        end
      end
    end
  end

  // Line monitor: decodes high-pulse widths into bits and checks frame framing
  initial begin
    logic prev_led = 1'b0;
    logic prev_busy = 1'b0;
    int   high_run = 0;
    int   bit_count = 0;
    int   last_rise = 0;
    bit   got;
    forever begin
      @(negedge clock_12mhz);
      cyc++;
      if (reset) begin
        exp_q.delete();
        prev_led  = 1'b0;
        prev_busy = 1'b0;
        high_run  = 0;
        bit_count = 0;
      end else begin
        if (led_data && !prev_led) begin
          last_rise = cyc;
          high_run  = 0;
        end
        if (led_data) high_run++;
        if (!led_data && prev_led) begin
          check_output("high_width", 32'(high_run == SEG_CLKS || high_run == 2 * SEG_CLKS), 32'd1);
          got = (high_run > (3 * SEG_CLKS) / 2);
          bit_count++;
          if (exp_q.size() == 0) fail_now("led_bit_unexpected");
          else check_output("led_bit", 32'(got), 32'(exp_q.pop_front()));
        end
        if (frame_busy && !prev_busy) begin
          check_output("underrun_cleared", 32'(underrun), 32'd0);
          bit_count = 0;
        end
        if (!frame_busy && prev_busy) begin
          check_output("frame_bits", 32'(bit_count), 32'(LED_COUNT * BITS_PER_LED));
          check_output("latch_len", 32'(cyc - last_rise), 32'((LATCH_BITS + 1) * BIT_CLKS));
          check_output("underrun_end", 32'(underrun), 32'(exp_underrun));
          check_output("sb_drained", 32'(exp_q.size()), 32'd0);
          check_output("req_count", 32'(req_count), 32'(LED_COUNT));
        end
        prev_led  = led_data;
        prev_busy = frame_busy;
      end
    end
  end

  task automatic pulse_framerate();
    framerate = 1'b1;
    repeat (10) @(negedge clock_12mhz);
    framerate = 1'b0;
  endtask

  // Starts one frame with the current plan; optionally fires a second
  // framerate edge mid-frame, which must be ignored.
  task automatic apply_stimulus(input bit overlap, input bit wait_end);
    int i;
    exp_underrun = 1'b0;
    for (int k = 1; k < LED_COUNT; k++) if (plan_late[k]) exp_underrun = 1'b1;
    for (i = 0; i < 4000 && frame_busy; i++) @(negedge clock_12mhz);
    if (frame_busy) fail_now("idle_timeout");
    pulse_framerate();
    if (!frame_busy) fail_now("frame_start");
    if (overlap) begin
      repeat (400) @(negedge clock_12mhz);
      pulse_framerate();
    end
    if (wait_end) begin
      for (i = 0; i < 4000 && frame_busy; i++) @(negedge clock_12mhz);
      if (frame_busy) fail_now("frame_end_timeout");
    end
  endtask

  task automatic plan_random();
    for (int k = 0; k < LED_COUNT; k++) begin
      plan_word[k] = 24'($urandom);
      plan_late[k] = 1'b0;
    end
  endtask

  initial begin
    bit saw_req;
    bit saw_busy;
    $display("[TB] start");
    repeat (5) @(negedge clock_12mhz);
    reset = 1'b0;
    @(negedge clock_12mhz);
    check_output("rst_led_data", 32'(led_data), 32'd0);
    check_output("rst_pixel_req", 32'(pixel_req), 32'd0);
    check_output("rst_pixel_addr", 32'(pixel_addr), 32'd0);
    check_output("rst_frame_busy", 32'(frame_busy), 32'd0);
    check_output("rst_underrun", 32'(underrun), 32'd0);

    // Basic frame with fixed words
    plan_random();
    plan_word[0] = 24'hFF0000;
    plan_word[1] = 24'h00000F;
    apply_stimulus(1'b0, 1'b1);

    // Byte-order word followed by random words
    plan_random();
    plan_word[0] = 24'h123456;
    apply_stimulus(1'b0, 1'b1);

    // LED 1 arrives after LED 0 has finished
    plan_random();
    plan_late[1] = 1'b1;
    apply_stimulus(1'b0, 1'b1);
    repeat (50) @(negedge clock_12mhz);
    check_output("underrun_sticky", 32'(underrun), 32'd1);

    // Second framerate edge mid-frame is dropped
    plan_random();
    apply_stimulus(1'b1, 1'b1);

    // Reset in the middle of shifting
    plan_random();
    apply_stimulus(1'b0, 1'b0);
    repeat (400) @(negedge clock_12mhz);
    reset = 1'b1;
    @(negedge clock_12mhz);
    check_output("midrst_led_data", 32'(led_data), 32'd0);
    check_output("midrst_frame_busy", 32'(frame_busy), 32'd0);
    check_output("midrst_pixel_req", 32'(pixel_req), 32'd0);
    @(negedge clock_12mhz);
    reset = 1'b0;
    saw_req  = 1'b0;
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clock_12mhz);
      saw_req  = saw_req | pixel_req;
      saw_busy = saw_busy | frame_busy;
    end
    check_output("post_rst_no_req", 32'(saw_req), 32'd0);
    check_output("post_rst_no_busy", 32'(saw_busy), 32'd0);

    // Normal frame after reset
    plan_random();
    apply_stimulus(1'b0, 1'b1);

    repeat (20) @(negedge clock_12mhz);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
